// File: rtl/fa_with_ha_pkg.sv
// Shared constants and types for the registered half-adder ripple-carry adder.
// Optional build macro handled elsewhere: FA_WITH_HA_OVF_EN.
package fa_with_ha_pkg;

    localparam int FA_WITH_HA_MAX_WIDTH = 64;

    // Exact (WIDTH+1)-bit result; sum is sized for the widest legal adder.
    typedef struct packed {
        logic                            carry_out;
        logic [FA_WITH_HA_MAX_WIDTH-1:0] sum;
    } fa_result_t;

endpackage

// File: rtl/fa_with_ha_reg_if.sv
// Operand/result bundle for fa_with_ha_reg; the master drives operands.
// FA_WITH_HA_OVF_EN adds the registered signed-overflow flag.
interface fa_with_ha_reg_if #(
    parameter int WIDTH = 1
) ();

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef FA_WITH_HA_OVF_EN
    logic             overflow;
`endif

    modport master (
        output in_valid, a, b, carry_in,
        input  out_valid, sum, carry_out
`ifdef FA_WITH_HA_OVF_EN
        , input overflow
`endif
    );

    modport slave (
        input  in_valid, a, b, carry_in,
        output out_valid, sum, carry_out
`ifdef FA_WITH_HA_OVF_EN
        , output overflow
`endif
    );

endinterface

// File: rtl/fa_with_ha_reg_ha_cell.sv
// Combinational half adder: the leaf cell of every full-adder bit.
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/fa_with_ha_reg.sv
// Ripple-carry adder of WIDTH full adders (two ha_cells + OR each), result registered.
// Build with FA_WITH_HA_OVF_EN to add the registered two's-complement overflow output.
module fa_with_ha_reg
    import fa_with_ha_pkg::*;
#(
    parameter int WIDTH = 1   // legal range 1..FA_WITH_HA_MAX_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    fa_with_ha_reg_if.slave   bus
);

    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_out_reg;
    logic             out_valid_reg;

    assign carry_chain[0] = bus.carry_in;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic p;
            logic g;
            logic t;

            ha_cell u_ha1 (
                .x (bus.a[gi]),
                .y (bus.b[gi]),
                .s (p),
                .c (g)
            );

            ha_cell u_ha2 (
                .x (p),
                .y (carry_chain[gi]),
                .s (sum_next[gi]),
                .c (t)
            );

            assign carry_chain[gi+1] = g | t;
        end
    endgenerate

    // Results load only on accepted operands, so idle-cycle inputs never reach the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                sum_reg       <= sum_next;
                carry_out_reg <= carry_chain[WIDTH];
            end
        end
    end

    assign bus.sum       = sum_reg;
    assign bus.carry_out = carry_out_reg;
    assign bus.out_valid = out_valid_reg;

`ifdef FA_WITH_HA_OVF_EN
    logic overflow_reg;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (bus.in_valid) begin
            overflow_reg <= carry_chain[WIDTH] ^ carry_chain[WIDTH-1];
        end
    end

    assign bus.overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_fa_with_ha_reg.sv
// Directed and random checks of fa_with_ha_reg at WIDTH=1 and WIDTH=8.
module tb_fa_with_ha_reg;
    import fa_with_ha_pkg::*;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    fa_with_ha_reg_if #(.WIDTH(1)) if1 ();
    fa_with_ha_reg_if #(.WIDTH(8)) if8 ();

    fa_with_ha_reg #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    fa_with_ha_reg #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_total++;
        if (if1.out_valid !== 1'b0 || if1.sum !== 1'b0 || if1.carry_out !== 1'b0)
            $display("FAIL reset_w1: got v=%b co=%b s=%b required 0 0 0",
                     if1.out_valid, if1.carry_out, if1.sum);
        else n_pass++;
        n_total++;
        if (if8.out_valid !== 1'b0 || if8.sum !== 8'h00 || if8.carry_out !== 1'b0)
            $display("FAIL reset_w8: got v=%b co=%b s=%h required 0 0 00",
                     if8.out_valid, if8.carry_out, if8.sum);
        else n_pass++;
`ifdef FA_WITH_HA_OVF_EN
        n_total++;
        if (if8.overflow !== 1'b0)
            $display("FAIL reset_ovf: got %b required 0", if8.overflow);
        else n_pass++;
`endif
        $display("txn reset: outputs after reset checked");
    endtask

    task automatic test_exhaustive_w1();
        logic [1:0] exp_tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vec;
            vec = 3'(v);
            if1.in_valid = 1'b1;
            if1.a        = vec[2];
            if1.b        = vec[1];
            if1.carry_in = vec[0];
            tick();
            $display("txn w1 abc=%b -> co,s=%b%b v=%b", vec, if1.carry_out, if1.sum, if1.out_valid);
            n_total++;
            if ({if1.carry_out, if1.sum} !== exp_tbl[v] || if1.out_valid !== 1'b1)
                $display("FAIL exhaustive_w1[%0d]: got co,s=%b%b v=%b required %b v=1",
                         v, if1.carry_out, if1.sum, if1.out_valid, exp_tbl[v]);
            else n_pass++;
        end
        if1.in_valid = 1'b0;
    endtask

    task automatic test_directed_w8();
        logic [7:0] ta [6] = '{8'hFF, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h01};
        logic [7:0] tb [6] = '{8'h01, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h01};
        logic       tc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] es [6] = '{8'h00, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h02};
        logic       ec [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       eo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if8.in_valid = 1'b1;
            if8.a        = ta[i];
            if8.b        = tb[i];
            if8.carry_in = tc[i];
            tick();
            $display("txn w8 %h+%h+%b -> co=%b s=%h v=%b", ta[i], tb[i], tc[i],
                     if8.carry_out, if8.sum, if8.out_valid);
            n_total++;
            if (if8.sum !== es[i] || if8.carry_out !== ec[i] || if8.out_valid !== 1'b1)
                $display("FAIL directed_w8[%0d]: got co=%b s=%h v=%b required co=%b s=%h v=1",
                         i, if8.carry_out, if8.sum, if8.out_valid, ec[i], es[i]);
            else n_pass++;
`ifdef FA_WITH_HA_OVF_EN
            n_total++;
            if (if8.overflow !== eo[i])
                $display("FAIL overflow_w8[%0d]: got %b required %b", i, if8.overflow, eo[i]);
            else n_pass++;
`else
            if (eo[i] === 1'bx) $display("txn unreachable");
`endif
        end
        if8.in_valid = 1'b0;
    endtask

    task automatic test_hold();
        if8.in_valid = 1'b1;
        if8.a        = 8'h12;
        if8.b        = 8'h34;
        if8.carry_in = 1'b0;
        tick();
        n_total++;
        if (if8.sum !== 8'h46 || if8.carry_out !== 1'b0 || if8.out_valid !== 1'b1)
            $display("FAIL hold_capture: got co=%b s=%h v=%b required co=0 s=46 v=1",
                     if8.carry_out, if8.sum, if8.out_valid);
        else n_pass++;
        if8.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if8.a        = 8'($urandom_range(0, 255));
            if8.b        = 8'($urandom_range(0, 255));
            if8.carry_in = 1'($urandom_range(0, 1));
            tick();
            $display("txn hold %0d: a=%h b=%h -> co=%b s=%h v=%b", i, if8.a, if8.b,
                     if8.carry_out, if8.sum, if8.out_valid);
            n_total++;
            if (if8.sum !== 8'h46 || if8.carry_out !== 1'b0 || if8.out_valid !== 1'b0)
                $display("FAIL hold[%0d]: got co=%b s=%h v=%b required co=0 s=46 v=0",
                         i, if8.carry_out, if8.sum, if8.out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        // Assert reset mid-cycle: no clock edge occurs before the check.
        #3;
        rst = 1'b1;
        #1;
        $display("txn async reset: co=%b s=%h v=%b", if8.carry_out, if8.sum, if8.out_valid);
        n_total++;
        if (if8.sum !== 8'h00 || if8.carry_out !== 1'b0 || if8.out_valid !== 1'b0)
            $display("FAIL async_reset: got co=%b s=%h v=%b required 0 00 0",
                     if8.carry_out, if8.sum, if8.out_valid);
        else n_pass++;
        if8.in_valid = 1'b1;
        if8.a        = 8'd3;
        if8.b        = 8'd4;
        if8.carry_in = 1'b1;
        tick();
        n_total++;
        if (if8.out_valid !== 1'b0 || if8.sum !== 8'h00)
            $display("FAIL reset_held: got s=%h v=%b required s=00 v=0", if8.sum, if8.out_valid);
        else n_pass++;
        rst = 1'b0;
        tick();
        $display("txn post-reset 3+4+1 -> co=%b s=%h v=%b", if8.carry_out, if8.sum, if8.out_valid);
        n_total++;
        if (if8.sum !== 8'h08 || if8.carry_out !== 1'b0 || if8.out_valid !== 1'b1)
            $display("FAIL post_reset: got co=%b s=%h v=%b required co=0 s=08 v=1",
                     if8.carry_out, if8.sum, if8.out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        fa_result_t exp_res;
        logic [8:0] full;
        logic       exp_ovf;
        int         errs;
        errs = 0;
        if8.in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if8.a        = 8'($urandom_range(0, 255));
            if8.b        = 8'($urandom_range(0, 255));
            if8.carry_in = 1'($urandom_range(0, 1));
            full = 9'(if8.a) + 9'(if8.b) + 9'(if8.carry_in);
            exp_res.carry_out = full[8];
            exp_res.sum       = 64'(full[7:0]);
            exp_ovf = (if8.a[7] == if8.b[7]) && (full[7] != if8.a[7]);
            tick();
            $display("txn b2b %0d: %h+%h+%b -> co=%b s=%h", i, if8.a, if8.b, if8.carry_in,
                     if8.carry_out, if8.sum);
            n_total++;
            if (if8.sum !== exp_res.sum[7:0] || if8.carry_out !== exp_res.carry_out ||
                if8.out_valid !== 1'b1) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL b2b[%0d]: got co=%b s=%h v=%b required co=%b s=%h v=1",
                             i, if8.carry_out, if8.sum, if8.out_valid,
                             exp_res.carry_out, exp_res.sum[7:0]);
            end else n_pass++;
`ifdef FA_WITH_HA_OVF_EN
            n_total++;
            if (if8.overflow !== exp_ovf) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL b2b_ovf[%0d]: got %b required %b", i, if8.overflow, exp_ovf);
            end else n_pass++;
`else
            if (exp_ovf === 1'bx) $display("txn unreachable");
`endif
        end
        if8.in_valid = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.carry_in = 1'b0;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.carry_in = 1'b0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_exhaustive_w1();
        test_directed_w8();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fa_with_ha_reg.md
Name: fa_with_ha_reg

Overview:
- Parameterised ripple-carry adder. Each bit is a full adder built from two half adders plus an OR gate.
- Computes sum = a + b + carry_in and registers the result on the clock, so outputs are glitch-free.
- Default WIDTH=1 gives the classic 1-bit full adder with a registered output.
- Used as an arithmetic leaf cell in datapaths and as a reference for adder verification.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid this cycle; qualifies capture.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- carry_in  in  1  carry into bit 0.
- out_valid  out  1  sum/carry_out updated by the last accepted operation.
- sum  out  WIDTH  registered (a + b + carry_in) modulo 2^WIDTH.
- carry_out  out  1  registered carry out of the MSB.

Behaviour:
- Reset is asynchronous and active-high. While rst=1: sum=0, carry_out=0, out_valid=0, all taken immediately, independent of clk.
- Bit cell i:
  - HA1: p = a[i]^b[i], g = a[i]&b[i].
  - HA2: s[i] = p^c[i], t = p&c[i].
  - c[i+1] = g|t; c[0] = carry_in.
  - Combinational ripple chain; carry_out = c[WIDTH].
- Latency 1 cycle. On a rising clk with rst=0 and in_valid=1, sum and carry_out load the combinational result; out_valid is set to 1 on the same edge.
- On a rising clk with in_valid=0: sum and carry_out hold their values; out_valid drops to 0.
- Back-to-back in_valid=1 is fully supported: throughput one operation per cycle, no stall, no backpressure.
- Arithmetic is unsigned modulo 2^WIDTH. {carry_out,sum} equals the exact (WIDTH+1)-bit result; wrap-around is signalled only via carry_out.
- Boundary conditions:
  - All-ones + all-ones + 1 gives sum = all-ones, carry_out = 1.
  - Zero + zero + 0 gives sum = 0, carry_out = 0.
- Reset asserted mid-stream: the pending result is discarded and outputs go to their reset values. The first capture after release is on the first rising clk with rst=0 and in_valid=1.
- X on inputs while in_valid=0 must not propagate to outputs.

Optional Feature:
- Macro FA_WITH_HA_OVF_EN.
- Defined: adds output port overflow, 1 bit. Registered with identical timing and hold rules as sum. overflow = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow. Reset value 0.
- Undefined: port absent and no related logic; behaviour otherwise identical.

Decomposition:
- Package fa_with_ha_pkg holds:
  - localparam FA_WITH_HA_MAX_WIDTH = 64.
  - typedef for the {carry_out,sum} result struct, used by the bench scoreboard.
- One sub-module, ha_cell: inputs x, y; outputs s = x^y, c = x&y. Purely combinational.
  - Instantiated twice per bit via a generate loop in fa_with_ha_reg.
  - The OR merge and output registers stay in the top module.

Test Plan:
- WIDTH=1, exhaustive: drive {a,b,carry_in}=0..7 with in_valid=1, one per cycle. Next cycle {carry_out,sum} must read 00,01,01,10,01,10,10,11 and out_valid=1.
- WIDTH=8, wrap-around: a=0xFF, b=0x01, carry_in=0 gives sum=0x00, carry_out=1 after 1 cycle. a=0xFF, b=0xFF, carry_in=1 gives sum=0xFF, carry_out=1.
- Hold: capture a=0x12, b=0x34, carry_in=0 (sum=0x46). Then in_valid=0 for 5 cycles with random a/b: sum stays 0x46, carry_out=0, out_valid=0 from the second cycle onward.
- Async reset mid-stream: assert rst between clock edges after sum=0x46. Outputs immediately read sum=0, carry_out=0, out_valid=0. After release with in_valid=1, a=3, b=4, carry_in=1, the next edge gives sum=8.
- Back-to-back random: 1000 consecutive in_valid=1 cycles at WIDTH=8. Every result must match a+b+carry_in one cycle later, with out_valid continuously 1.
- With FA_WITH_HA_OVF_EN, WIDTH=8: 0x7F+0x01+0 gives overflow=1; 0x80+0x80+0 gives overflow=1, carry_out=1; 0x01+0x01+0 gives overflow=0.
